// File: rtl/stream_mux_nx1_if.sv
// Handshake bundle between N stream producers, the mux and one consumer.
// master = the mux side (drives in_ready and the output beat), slave = the environment.
interface stream_mux_nx1_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
);
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic [SELW-1:0] grant_id;

  modport master (
    input  in_data, in_valid, in_last, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, grant_id
  );

  modport slave (
    output in_data, in_valid, in_last, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant_id
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// N-input valid/ready stream mux with registered output, select or round-robin
// arbitration, and packet locking so multi-beat packets are never interleaved.
module stream_mux_nx1 #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input logic              clk,
  input logic              rst_n,
  stream_mux_nx1_if.master bus
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_lock_ch, w_lock_ch_nxt;
  logic [SELW-1:0] r_last_grant, w_last_grant_nxt;
  logic [W-1:0]    r_out_data;
  logic            r_out_valid, r_out_last;
  logic [SELW-1:0] r_grant_id;

  logic            w_can_load, w_chosen, w_accept, w_rr_found, w_sel_last;
  logic [SELW-1:0] w_cur, w_rr_ch;
  logic [N-1:0]    w_in_ready;
  logic [W-1:0]    w_sel_data;

  // Two passes: channels above last_grant first, then wrap to the low ones.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_ch    = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_rr_found && bus.in_valid[i] && i > int'(r_last_grant)) begin
        w_rr_found = 1'b1;
        w_rr_ch    = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_rr_found && bus.in_valid[i] && i <= int'(r_last_grant)) begin
        w_rr_found = 1'b1;
        w_rr_ch    = SELW'(i);
      end
    end
  end

  always_comb begin
    w_chosen = 1'b0;
    w_cur    = '0;
    if (r_state == LOCK) begin
      w_chosen = 1'b1;
      w_cur    = r_lock_ch;
    end else if (bus.mode) begin
      w_chosen = w_rr_found;
      w_cur    = w_rr_ch;
    end else begin
      w_chosen = int'(bus.sel) < N;
      w_cur    = bus.sel;
    end
  end

  assign w_can_load = !r_out_valid || bus.out_ready;

  // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
  always_comb begin
    w_in_ready = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_cur == SELW'(i)) begin
        w_in_ready[i] = rst_n && w_can_load && w_chosen;
        w_sel_data    = bus.in_data[i*W +: W];
        w_sel_last    = bus.in_last[i];
      end
    end
  end

  assign w_accept = |(w_in_ready & bus.in_valid);

  always_comb begin
    w_state_nxt      = r_state;
    w_lock_ch_nxt    = r_lock_ch;
    w_last_grant_nxt = r_last_grant;
    if (w_accept) begin
      if (w_sel_last) begin
        w_state_nxt      = IDLE;
        w_last_grant_nxt = w_cur;
      end else begin
        w_state_nxt   = LOCK;
        w_lock_ch_nxt = w_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lock_ch    <= '0;
      r_last_grant <= SELW'(N - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_lock_ch    <= w_lock_ch_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_grant_id  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_grant_id  <= w_cur;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.grant_id  = r_grant_id;
endmodule
